// File: rtl/spi_slave_if_if.sv
// Bundle of the SPI pins and the RAM-side word/byte handshake of the SPI slave front end.
// The slave modport is the front end's view; the master modport is the SPI master plus RAM side.
interface spi_slave_if_if #(
    parameter int RX_W = 10,
    parameter int TX_W = 8
);
    logic            SS_n;
    logic            MOSI;
    logic            MISO;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid;

    modport slave (
        input  SS_n,
        input  MOSI,
        input  tx_data,
        input  tx_valid,
        output MISO,
        output rx_data,
        output rx_valid
    );

    modport master (
        output SS_n,
        output MOSI,
        output tx_data,
        output tx_valid,
        input  MISO,
        input  rx_data,
        input  rx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave serial front end: shifts MOSI frames into RX_W-bit RAM words and
// returns one RAM read byte on MISO, MSB first, during a read-data frame.
module spi_slave_if #(
    parameter int RX_W = 10,
    parameter int TX_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    spi_slave_if_if.slave bus
);
    localparam int CNT_W    = $clog2(RX_W + 1);
    localparam int TX_CNT_W = $clog2(TX_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [RX_W-1:0]     rx_shift_reg;
    logic [RX_W-1:0]     rx_shift_next;
    logic [RX_W-1:0]     rx_data_reg;
    logic                rx_valid_reg;
    logic                rd_addr_seen_reg;
    logic [TX_W-1:0]     tx_shift_reg;
    logic [TX_CNT_W-1:0] tx_cnt_reg;
    logic                tx_done_reg;
    logic                miso_reg;

    logic in_payload;
    logic shift_en;
    logic last_bit;
    logic tx_load;

    // MSB-first shift: new bit enters at bit 0, older bits move toward the MSB.
    assign rx_shift_next[0] = bus.MOSI;
    generate
        for (genvar gi = 1; gi < RX_W; gi++) begin : g_rx_shift
            assign rx_shift_next[gi] = rx_shift_reg[gi-1];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode plus the per-edge datapath enables.
    always_comb begin
        state_next = state_reg;
        in_payload = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!bus.SS_n) state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n)             state_next = IDLE;
                else if (!bus.MOSI)       state_next = WRITE;
                else if (rd_addr_seen_reg) state_next = READ_DATA;
                else                      state_next = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) state_next = IDLE;
                else          in_payload = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        // Counter saturates at RX_W, so bits past the word are ignored.
        shift_en = in_payload && (bit_cnt_reg != CNT_W'(RX_W));
        last_bit = shift_en && (bit_cnt_reg == CNT_W'(RX_W - 1));
        // Read byte is accepted only once, and only after the word has completed.
        tx_load  = in_payload && (state_reg == READ_DATA) &&
                   (bit_cnt_reg == CNT_W'(RX_W)) && !tx_done_reg && bus.tx_valid;
    end

    // Receive shifter, word strobe, read-address tracking and MISO serialiser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_reg      <= '0;
            rx_shift_reg     <= '0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            rd_addr_seen_reg <= 1'b0;
            tx_shift_reg     <= '0;
            tx_cnt_reg       <= '0;
            tx_done_reg      <= 1'b0;
            miso_reg         <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            if (!in_payload) begin
                // Outside a payload phase (including an abort) nothing is in flight.
                bit_cnt_reg <= '0;
                tx_cnt_reg  <= '0;
                tx_done_reg <= 1'b0;
                miso_reg    <= 1'b0;
            end else begin
                if (shift_en) begin
                    rx_shift_reg <= rx_shift_next;
                    bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                end
                if (last_bit) begin
                    rx_data_reg  <= rx_shift_next;
                    rx_valid_reg <= 1'b1;
                    if (state_reg == READ_ADD)  rd_addr_seen_reg <= 1'b1;
                    if (state_reg == READ_DATA) rd_addr_seen_reg <= 1'b0;
                end
                if (tx_load) begin
                    miso_reg     <= bus.tx_data[TX_W-1];
                    tx_shift_reg <= {bus.tx_data[TX_W-2:0], 1'b0};
                    tx_cnt_reg   <= TX_CNT_W'(TX_W - 1);
                    tx_done_reg  <= 1'b1;
                end else if (tx_cnt_reg != '0) begin
                    miso_reg     <= tx_shift_reg[TX_W-1];
                    tx_shift_reg <= {tx_shift_reg[TX_W-2:0], 1'b0};
                    tx_cnt_reg   <= tx_cnt_reg - 1'b1;
                end else begin
                    miso_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.MISO     = miso_reg;
    assign bus.rx_data  = rx_data_reg;
    assign bus.rx_valid = rx_valid_reg;
endmodule

// File: tb/tb_spi_slave_if.sv
// Testbench for spi_slave_if: directed frame table, hand-written reset sequences
// and random frames, all checked cycle by cycle against a frame-level model.
module tb_spi_slave_if;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_if_if #(.RX_W(10), .TX_W(8)) bus ();
    spi_slave_if #(.RX_W(10), .TX_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int vectors     = 0;
    int miscompares = 0;

    // Model state: what the slave remembers between frames.
    logic       rd_seen_m = 1'b0;
    logic [9:0] rx_m      = '0;

    typedef struct {
        logic       sel;
        logic [9:0] pl;
        int         low_len;
        int         e1;
        logic [7:0] b1;
        int         e2;
        logic [7:0] b2;
        logic [9:0] exp_rx;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
        bus.SS_n     = ss;
        bus.MOSI     = mosi;
        bus.tx_valid = txv;
        bus.tx_data  = txd;
        @(posedge clk);
        #1;
    endtask

    // Edge 0: SS_n low seen in IDLE; edge 1: select bit; edges 2.. : payload then
    // filler while SS_n stays low; edge L = 2+low_len: SS_n high ends the frame.
    // tx_valid is pulsed at edges e1/e2 (-1 = none).
    task automatic run_frame(input int id, input logic sel, input logic [9:0] pl, input int low_len,
                             input int e1, input logic [7:0] b1, input int e2, input logic [7:0] b2);
        int         L;
        bit         comp;
        int         mode;
        int         k;
        logic [7:0] kb;
        logic       mosi, txv, exp_valid, exp_miso;
        logic [7:0] txd;
        logic [9:0] exp_data;
        L    = 2 + low_len;
        comp = (low_len >= 10);
        mode = (sel == 1'b0) ? 0 : (rd_seen_m ? 2 : 1);
        k    = -1;
        kb   = '0;
        if (comp && mode == 2) begin
            if (e1 >= 12 && e1 < L) begin k = e1; kb = b1; end
            if (e2 >= 12 && e2 < L && (k < 0 || e2 < k)) begin k = e2; kb = b2; end
        end
        for (int e = 0; e <= L; e++) begin
            if (e == 1)                    mosi = sel;
            else if (e >= 2 && e - 2 < 10) mosi = pl[9-(e-2)];
            else                           mosi = 1'($urandom_range(0, 1));
            txv = (e == e1) || (e == e2);
            txd = (e == e1) ? b1 : (e == e2) ? b2 : 8'($urandom);
            step(e == L, mosi, txv, txd);
            exp_valid = comp && (e == 11);
            exp_data  = (comp && e >= 11) ? pl : rx_m;
            exp_miso  = (k >= 0 && e >= k && e <= k + 7 && e < L) ? kb[7-(e-k)] : 1'b0;
            chk("rx_valid", 32'(bus.rx_valid), 32'(exp_valid));
            chk("rx_data",  32'(bus.rx_data),  32'(exp_data));
            chk("miso",     32'(bus.MISO),     32'(exp_miso));
        end
        if (comp) begin
            rx_m = pl;
            if (mode == 1) rd_seen_m = 1'b1;
            if (mode == 2) rd_seen_m = 1'b0;
        end
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        chk("idle_rx_valid", 32'(bus.rx_valid), 32'(0));
        chk("idle_miso",     32'(bus.MISO),     32'(0));
        $display("frame %0d sel=%0d payload=%03h low=%0d mode=%0d rx_data=%03h", id, sel, pl, low_len, mode, bus.rx_data);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_miso",     32'(bus.MISO),     32'(0));
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'(0));
        chk("rst_rx_data",  32'(bus.rx_data),  32'(0));
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        rx_m      = '0;
        rd_seen_m = 1'b0;
        $display("reset applied rx_data=%03h miso=%0d", bus.rx_data, bus.MISO);
    endtask

    initial begin
        bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
        rst = 1'b0;
        #1;
        do_reset();

        tbl[0] = '{1'b0, 10'h0A5, 10, -1, 8'h00, -1, 8'h00, 10'h0A5};
        tbl[1] = '{1'b1, 10'h203, 10, -1, 8'h00, -1, 8'h00, 10'h203};
        tbl[2] = '{1'b1, 10'h300, 21, 13, 8'hC3, -1, 8'h00, 10'h300};
        tbl[3] = '{1'b1, 10'h155, 10, -1, 8'h00, -1, 8'h00, 10'h155};
        tbl[4] = '{1'b1, 10'h0F0, 22, 12, 8'h5A, -1, 8'h00, 10'h0F0};
        tbl[5] = '{1'b0, 10'h2AA,  6, -1, 8'h00, -1, 8'h00, 10'h0F0};
        tbl[6] = '{1'b0, 10'h1FF, 10, -1, 8'h00, -1, 8'h00, 10'h1FF};
        tbl[7] = '{1'b0, 10'h111, 14,  5, 8'hAA, 13, 8'hAA, 10'h111};
        tbl[8] = '{1'b1, 10'h0C3, 10, -1, 8'h00, -1, 8'h00, 10'h0C3};
        tbl[9] = '{1'b1, 10'h3C0, 24, 14, 8'hAA, 16, 8'h55, 10'h3C0};

        for (int i = 0; i < 10; i++) begin
            run_frame(i, tbl[i].sel, tbl[i].pl, tbl[i].low_len, tbl[i].e1, tbl[i].b1, tbl[i].e2, tbl[i].b2);
            chk("tbl_rx_data", 32'(bus.rx_data), 32'(tbl[i].exp_rx));
        end

        // Reset in the middle of a write frame.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
        do_reset();
        run_frame(20, 1'b0, 10'h2C7, 10, -1, 8'h00, -1, 8'h00);

        // Reset while MISO is shifting a read byte; the read address must be forgotten.
        run_frame(21, 1'b1, 10'h045, 10, -1, 8'h00, -1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int e = 2; e <= 14; e++) step(1'b0, 1'b1, e == 12, 8'hFF);
        chk("mid_read_miso", 32'(bus.MISO), 32'(1));
        do_reset();
        run_frame(22, 1'b1, 10'h321, 22, 12, 8'hFF, -1, 8'h00);
        run_frame(23, 1'b1, 10'h0AB, 22, 12, 8'h96, -1, 8'h00);

        // Random frames.
        for (int i = 0; i < 40; i++) begin
            int e1, e2;
            e1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 26)) : -1;
            e2 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 26)) : -1;
            run_frame(100 + i, 1'($urandom_range(0, 1)), 10'($urandom), int'($urandom_range(4, 24)),
                      e1, 8'($urandom), e2, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
